// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and helpers for the FIFO read-side packer and its idle timer.
package fifo_rd_packer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PACK       = 4;
    localparam int OUT_W          = DEF_DATA_WIDTH * DEF_PACK;
    localparam int MAX_PACK       = 64;

    // Contiguous lane mask with the low 'count' bits set, i.e. (1<<count)-1.
    function automatic logic [MAX_PACK-1:0] keep_mask(input int count);
        logic [MAX_PACK-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_PACK; i++) begin
            if (i < count) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_idle_timer.sv
// Saturating idle counter; expired_o rises once the count reaches TIMEOUT.
module fifo_rd_idle_timer
    import fifo_rd_packer_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TMR_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT);

    logic [TMR_W-1:0] tmr_q, tmr_d;

    always_comb begin
        tmr_d = tmr_q;
        if (clr_i) begin
            tmr_d = '0;
        end else if (en_i && (tmr_q != LIMIT)) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    // A zero TIMEOUT disables flushing altogether.
    assign expired_o = (TIMEOUT != 0) && (tmr_q == LIMIT);

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains the async FIFO read port, packing PACK entries per output word and
// flushing a partial word with a keep mask after an idle timeout.
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PACK       = DEF_PACK,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = $clog2(PACK + 1),
    parameter int TMR_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                       rd_clk,
    input  logic                       rst,
    input  logic                       empty,
    input  logic [DATA_WIDTH-1:0]      rdata,
    output logic                       rd_en,
    output logic [DATA_WIDTH*PACK-1:0] out_data,
    output logic [PACK-1:0]            out_keep,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       flush_pulse
);

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       inflight_q, inflight_d;
    logic [DATA_WIDTH*PACK-1:0] lanes_q, lanes_d;
    logic [PACK-1:0]            keep_q, keep_d;
    logic                       flush_q, flush_d;
    logic                       run_q;
    logic                       room, tmr_expired, flush_fire, tmr_clr, tmr_en;

    assign room       = (int'(count_q) + int'(inflight_q)) < PACK;
    assign flush_fire = tmr_expired && (state_q == FILL) && !inflight_q;

    // run_q keeps rd_en low while reset is held even if the FIFO is non-empty;
    // masking with flush_fire makes a timeout win over a newly arrived entry.
    assign rd_en   = run_q && !empty && (state_q != HOLD) && room && !flush_fire;
    assign tmr_clr = rd_en || inflight_q || (state_q != FILL);
    assign tmr_en  = (state_q == FILL) && !inflight_q && empty;

    fifo_rd_idle_timer #(
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) u_idle_timer (
        .clk_i     (rd_clk),
        .rst_ni    (rst),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        inflight_d = rd_en;
        lanes_d    = lanes_q;
        keep_d     = keep_q;
        flush_d    = 1'b0;

        // rdata is valid the cycle after an accepted pop.
        if (inflight_q) begin
            for (int i = 0; i < PACK; i++) begin
                if (count_q == CNT_W'(i)) lanes_d[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
            end
            if (count_q != CNT_W'(PACK)) count_d = count_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (rd_en) state_d = FILL;
            end
            FILL: begin
                if (inflight_q && (count_q == CNT_W'(PACK - 1))) begin
                    state_d = HOLD;
                    keep_d  = PACK'(keep_mask(PACK));
                end else if (flush_fire) begin
                    state_d = HOLD;
                    keep_d  = PACK'(keep_mask(int'(count_q)));
                    flush_d = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    count_d = '0;
                    lanes_d = '0;
                    keep_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            inflight_q <= 1'b0;
            lanes_q    <= '0;
            keep_q     <= '0;
            flush_q    <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            lanes_q    <= lanes_d;
            keep_q     <= keep_d;
            flush_q    <= flush_d;
            run_q      <= 1'b1;
        end
    end

    assign out_data    = lanes_q;
    assign out_keep    = keep_q;
    assign out_valid   = (state_q == HOLD);
    assign flush_pulse = flush_q;

endmodule
